// File: rtl/svf_driver_if.sv
// Filter-side bus between svf_driver (master) and the state-variable filter (slave).
interface svf_driver_if;
  logic               svf_ena;
  logic signed [11:0] svf_in;
  logic signed [17:0] svf_f;
  logic signed [17:0] svf_q;
  logic signed [17:0] svf_out;

  modport master (
    output svf_ena,
    output svf_in,
    output svf_f,
    output svf_q,
    input  svf_out
  );

  modport slave (
    input  svf_ena,
    input  svf_in,
    input  svf_f,
    input  svf_q,
    output svf_out
  );
endinterface

// File: rtl/svf_driver.sv
// Sample-rate sequencer for a state-variable filter: strobes the filter once per DIV clocks,
// then captures its result SETTLE clocks later. Define SVF_DRIVER_SLEW_EN for coefficient slewing.
module svf_driver #(
  parameter int unsigned        DIV    = 1024,
  parameter int unsigned        SETTLE = 5,
  parameter logic signed [17:0] FMAX   = 18'sd65536,
  parameter logic signed [17:0] QMIN   = 18'sd5586,
  parameter logic signed [17:0] FSTEP  = 18'sd64,
  parameter logic signed [17:0] QSTEP  = 18'sd256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic signed [11:0]  sample_in,
  input  logic signed [17:0]  f_target,
  input  logic signed [17:0]  q_target,
  svf_driver_if.master        svf,
  output logic signed [17:0]  out_sample,
  output logic                out_valid
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned SW = $clog2(SETTLE);

  if (DIV < 8 || DIV > 65535) begin : g_bad_div
    $error("svf_driver: DIV out of range");
  end
  if (SETTLE < 5 || SETTLE >= DIV || FSTEP <= 0 || QSTEP <= 0) begin : g_bad_cfg
    $error("svf_driver: SETTLE/FSTEP/QSTEP out of range");
  end

  typedef enum logic [1:0] {StIdle, StWait, StCapture} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [SW-1:0]      settle_q;
  logic               wrap;
  logic signed [17:0] f_eff, q_eff, f_next, q_next;

  assign wrap = run && (cnt_q == CW'(DIV - 1));

  always_comb begin
    f_eff = f_target;
    if (f_target < 0) begin
      f_eff = '0;
    end else if (f_target > FMAX) begin
      f_eff = FMAX;
    end
    q_eff = (q_target < QMIN) ? QMIN : q_target;
  end

`ifdef SVF_DRIVER_SLEW_EN
  logic signed [18:0] f_diff, q_diff;

  // Differences are one bit wider so the full 18-bit range cannot wrap.
  always_comb begin
    f_diff = 19'(f_eff) - 19'(svf.svf_f);
    q_diff = 19'(q_eff) - 19'(svf.svf_q);
    f_next = f_eff;
    q_next = q_eff;
    if (f_diff > 19'(FSTEP)) begin
      f_next = svf.svf_f + FSTEP;
    end else if (f_diff < -19'(FSTEP)) begin
      f_next = svf.svf_f - FSTEP;
    end
    if (q_diff > 19'(QSTEP)) begin
      q_next = svf.svf_q + QSTEP;
    end else if (q_diff < -19'(QSTEP)) begin
      q_next = svf.svf_q - QSTEP;
    end
  end
`else
  always_comb begin
    f_next = f_eff;
    q_next = q_eff;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      settle_q    <= '0;
      state_q     <= StIdle;
      svf.svf_ena <= 1'b0;
      svf.svf_in  <= '0;
      svf.svf_f   <= '0;
      svf.svf_q   <= 18'sd131071;
      out_sample  <= '0;
      out_valid   <= 1'b0;
    end else begin
      svf.svf_ena <= wrap;
      out_valid   <= 1'b0;
      if (run) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
      if (wrap) begin
        svf.svf_in <= sample_in;
        svf.svf_f  <= f_next;
        svf.svf_q  <= q_next;
      end
      case (state_q)
        StWait: begin
          // Capture is independent of run so a dropped run cannot strand a pending result.
          if (settle_q == '0) begin
            state_q    <= StCapture;
            out_sample <= svf.svf_out;
            out_valid  <= 1'b1;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        default: begin
          // Leaving CAPTURE also checks wrap so SETTLE = DIV-1 still starts the next wait.
          if (wrap) begin
            state_q  <= StWait;
            settle_q <= SW'(SETTLE - 1);
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svf_driver.sv
// Directed bench for svf_driver with DIV=16, SETTLE=5; expectations follow SVF_DRIVER_SLEW_EN.
module tb_svf_driver;

  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic signed [11:0] sample_in;
  logic signed [17:0] f_target;
  logic signed [17:0] q_target;
  logic signed [17:0] out_sample;
  logic               out_valid;

  int n_checks = 0;
  int n_errors = 0;

  svf_driver_if svf ();

  svf_driver #(
    .DIV    (16),
    .SETTLE (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .sample_in  (sample_in),
    .f_target   (f_target),
    .q_target   (q_target),
    .svf        (svf),
    .out_sample (out_sample),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int exp_in_a [3] = '{-2047, 5, 1000};
`ifdef SVF_DRIVER_SLEW_EN
  int exp_f_a  [3] = '{0, 64, 128};
  int exp_q_a  [3] = '{130815, 130559, 130815};
  int exp_fb       = 64;
  int exp_fd_a [5] = '{64, 128, 192, 200, 200};
  int exp_qd_a [5] = '{130815, 130559, 130303, 130047, 130000};
`else
  int exp_f_a  [3] = '{0, 65536, 200};
  int exp_q_a  [3] = '{5586, 30000, 131071};
  int exp_fb       = 200;
  int exp_fd_a [5] = '{200, 200, 200, 200, 200};
  int exp_qd_a [5] = '{130000, 130000, 130000, 130000, 130000};
`endif

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ena"}, svf.svf_ena, 0);
    check({tag, " valid"}, out_valid, 0);
    check({tag, " svf_in"}, svf.svf_in, 0);
    check({tag, " svf_f"}, svf.svf_f, 0);
    check({tag, " svf_q"}, svf.svf_q, 131071);
    check({tag, " out_sample"}, out_sample, 0);
  endtask

  initial begin
    int w;
    reset       = 1'b1;
    run         = 1'b0;
    sample_in   = '0;
    f_target    = '0;
    q_target    = '0;
    svf.svf_out = 18'sd777;
    repeat (3) @(negedge clk);
    check_reset_state("init");

    // Wraps at 16/32/48; targets changed mid-period must wait for the next wrap.
    reset     = 1'b0;
    run       = 1'b1;
    sample_in = -12'sd2047;
    f_target  = -18'sd5;
    q_target  = 18'sd100;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      check("ena", svf.svf_ena, (k % 16) == 0);
      check("valid", out_valid, k >= 16 && (k % 16) == 5);
      if (k == 21) check("out_sample", out_sample, 777);
      if (k == 37) check("out_sample", out_sample, -1234);
      if (k < 16) begin
        check("svf_in pre", svf.svf_in, 0);
        check("svf_f pre", svf.svf_f, 0);
        check("svf_q pre", svf.svf_q, 131071);
      end else begin
        w = k / 16 - 1;
        check("svf_in", svf.svf_in, exp_in_a[w]);
        check("svf_f", svf.svf_f, exp_f_a[w]);
        check("svf_q", svf.svf_q, exp_q_a[w]);
      end
      if (k == 18) begin
        sample_in = 12'sd5;
        f_target  = 18'sd100000;
        q_target  = 18'sd30000;
      end
      if (k == 34) begin
        sample_in   = 12'sd1000;
        f_target    = 18'sd200;
        q_target    = 18'sd131071;
        svf.svf_out = -18'sd1234;
      end
    end

    // Reset two clocks after the wrap-48 strobe abandons the pending capture.
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid-wait reset");
    reset = 1'b0;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      check("ena after reset", svf.svf_ena, j == 16 || j == 75);
      check("valid after reset", out_valid, j == 21 || j == 80);
      if (j == 15) begin
        check("svf_in held reset", svf.svf_in, 0);
        check("svf_f held reset", svf.svf_f, 0);
      end
      if (j == 16) begin
        check("svf_in after reset", svf.svf_in, 1000);
        check("svf_f after reset", svf.svf_f, exp_fb);
        check("svf_q after reset", svf.svf_q, 131071);
      end
      if (j == 21) check("out_sample run low", out_sample, -1234);
      if (j == 17) run = 1'b0;
      if (j == 60) run = 1'b1;
    end

    // Slew sequence from a fresh reset.
    reset    = 1'b1;
    f_target = 18'sd200;
    q_target = 18'sd130000;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      check("ena slew", svf.svf_ena, (k % 16) == 0);
      if ((k % 16) == 0) begin
        check("svf_f slew", svf.svf_f, exp_fd_a[k / 16 - 1]);
        check("svf_q slew", svf.svf_q, exp_qd_a[k / 16 - 1]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
